// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction-fetch sequencer that steers the program counter. It walks
// 1-byte ordinary opcodes and 2-byte branch instructions (JMP, JZ/JNZ,
// JC/JNC, CALL). It resolves RET from an internal return-address stack and
// parks in HALT on HLT. Ordinary opcodes are handed to the execute path
// through ir/exec_valid.
//
// Parameters:
//   STACK_DEPTH  number of return-address entries (1..16)
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   pc_addr     current PC value
//   instr       program-memory byte at pc_addr (combinational read)
//   stall       hold request; freezes the sequencer and the PC
//   zero_flag   ALU Z flag, sampled in the operand cycle of a branch
//   carry_flag  ALU CY flag, sampled in the operand cycle of a branch
//   pc_jump     PC load strobe (combinational)
//   pc_jmpaddr  PC load value, 00 whenever pc_jump is low (combinational)
//   pc_freeze   PC hold (combinational)
//   ir          latched opcode (registered)
//   exec_valid  one-cycle pulse: ir holds an ordinary opcode to execute
//   halted      high while parked in HALT
//   stack_err   sticky return-stack overflow/underflow flag
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pc_addr,
    input  logic [7:0] instr,
    input  logic       stall,
    input  logic       zero_flag,
    input  logic       carry_flag,
    output logic       pc_jump,
    output logic [7:0] pc_jmpaddr,
    output logic       pc_freeze,
    output logic [7:0] ir,
    output logic       exec_valid,
    output logic       halted,
    output logic       stack_err
);

    // The pointer counts entries, so it must be able to hold STACK_DEPTH itself.
    localparam int PW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [7:0] OP_JMP  = 8'hC3;
    localparam logic [7:0] OP_JNZ  = 8'hC2;
    localparam logic [7:0] OP_JZ   = 8'hCA;
    localparam logic [7:0] OP_JNC  = 8'hD2;
    localparam logic [7:0] OP_JC   = 8'hDA;
    localparam logic [7:0] OP_CALL = 8'hCD;
    localparam logic [7:0] OP_RET  = 8'hC9;
    localparam logic [7:0] OP_HLT  = 8'h76;

    typedef enum logic [1:0] {
        S_FETCH,
        S_OPERAND,
        S_HALT
    } state_t;

    state_t          state;
    logic [PW-1:0]   sp;
    logic [7:0]      stack [STACK_DEPTH];

    logic            stack_empty;
    logic            stack_full;
    logic [IW-1:0]   top_idx;
    logic [IW-1:0]   push_idx;
    logic [7:0]      ret_addr;
    logic            taken;
    logic            call_ok;
    logic            push_en;

    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == PW'(STACK_DEPTH));
    assign top_idx     = IW'(sp - PW'(1));
    assign push_idx    = IW'(sp);
    // In the operand cycle pc_addr points at the target byte, so the return
    // address is the byte after it; the 8-bit add wraps FF to 00.
    assign ret_addr    = pc_addr + 8'd1;

    // Branch condition for the opcode held in ir while its operand is on instr.
    always_comb begin
        taken = 1'b0;
        case (ir)
            OP_JMP, OP_CALL: taken = 1'b1;
            OP_JZ:           taken = zero_flag;
            OP_JNZ:          taken = ~zero_flag;
            OP_JC:           taken = carry_flag;
            OP_JNC:          taken = ~carry_flag;
            default:         taken = 1'b0;
        endcase
    end

    // A CALL against a full stack degrades to a fall-through.
    assign call_ok = (ir != OP_CALL) || !stack_full;
    assign push_en = (state == S_OPERAND) && !stall && (ir == OP_CALL) && !stack_full;

    // PC steering is combinational so the PC reacts in the same cycle the
    // opcode or operand is presented; reset forces a safe frozen PC.
    always_comb begin
        pc_jump    = 1'b0;
        pc_jmpaddr = 8'h00;
        pc_freeze  = 1'b0;
        if (reset) begin
            pc_freeze = 1'b1;
        end else begin
            case (state)
                S_FETCH: begin
                    if (stall || instr == OP_HLT) begin
                        pc_freeze = 1'b1;
                    end else if (instr == OP_RET && !stack_empty) begin
                        pc_jump    = 1'b1;
                        pc_jmpaddr = stack[top_idx];
                    end
                end
                S_OPERAND: begin
                    if (stall) begin
                        pc_freeze = 1'b1;
                    end else if (taken && call_ok) begin
                        pc_jump    = 1'b1;
                        pc_jmpaddr = instr;
                    end
                end
                default: pc_freeze = 1'b1;
            endcase
        end
    end

    // Sequencer FSM. exec_valid defaults low so it can only ever be a single
    // cycle pulse; a stalled cycle leaves every other register untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            ir         <= 8'h00;
            exec_valid <= 1'b0;
            halted     <= 1'b0;
            stack_err  <= 1'b0;
            sp         <= '0;
        end else begin
            exec_valid <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (!stall) begin
                        case (instr)
                            OP_HLT: begin
                                ir     <= instr;
                                halted <= 1'b1;
                                state  <= S_HALT;
                            end
                            OP_JMP, OP_JNZ, OP_JZ, OP_JNC, OP_JC, OP_CALL: begin
                                ir    <= instr;
                                state <= S_OPERAND;
                            end
                            OP_RET: begin
                                if (stack_empty) begin
                                    stack_err <= 1'b1;
                                end else begin
                                    sp <= sp - PW'(1);
                                end
                            end
                            default: begin
                                ir         <= instr;
                                exec_valid <= 1'b1;
                            end
                        endcase
                    end
                end
                S_OPERAND: begin
                    if (!stall) begin
                        if (ir == OP_CALL) begin
                            if (stack_full) begin
                                stack_err <= 1'b1;
                            end else begin
                                sp <= sp + PW'(1);
                            end
                        end
                        state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    halted <= 1'b1;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // Return-address storage needs no reset; only entries below sp are read.
    always_ff @(posedge clk) begin
        if (push_en && !reset) begin
            stack[push_idx] <= ret_addr;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Testbench for fetch_ctrl. A behavioural program memory and a PC with
// synchronous reset surround the DUT, so instruction streams run end to end.
// A table of two-byte programs covers branch decode. Hand-written sequences
// cover HLT, CALL/RET, stack overflow/underflow, return-address wrap, stalls
// and reset in mid-instruction.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] pc_addr;
    logic [7:0] instr;
    logic       stall;
    logic       zero_flag;
    logic       carry_flag;
    logic       pc_jump;
    logic [7:0] pc_jmpaddr;
    logic       pc_freeze;
    logic [7:0] ir;
    logic       exec_valid;
    logic       halted;
    logic       stack_err;

    logic [7:0] mem [256];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] op;
        logic [7:0] tgt;
        logic       z;
        logic       cy;
        logic       exp_jump;
        logic [7:0] exp_pc3;
    } vec_t;

    vec_t vecs [10];

    fetch_ctrl #(.STACK_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_addr    (pc_addr),
        .instr      (instr),
        .stall      (stall),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .pc_jump    (pc_jump),
        .pc_jmpaddr (pc_jmpaddr),
        .pc_freeze  (pc_freeze),
        .ir         (ir),
        .exec_valid (exec_valid),
        .halted     (halted),
        .stack_err  (stack_err)
    );

    always #5 clk = ~clk;

    // Program memory read is combinational, as seen by the sequencer.
    assign instr = mem[pc_addr];

    // Program counter with synchronous reset sharing the reset net.
    always @(posedge clk) begin
        if (reset)
            pc_addr <= 8'h00;
        else if (pc_jump)
            pc_addr <= pc_jmpaddr;
        else if (!pc_freeze)
            pc_addr <= pc_addr + 8'd1;
    end

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%02h required=%02h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Clears memory to NOPs and loads a two-byte program at 00 with flags.
    task automatic apply_stimulus(input logic [7:0] op, input logic [7:0] tgt,
                                  input logic z, input logic cy);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0]     = op;
        mem[1]     = tgt;
        zero_flag  = z;
        carry_flag = cy;
    endtask

    // Leaves the bench at the negedge of cycle 1 (opcode at 00 presented).
    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'hC3, 8'h40, 1'b0, 1'b0, 1'b1, 8'h40};
        vecs[1] = '{8'hCA, 8'h20, 1'b0, 1'b0, 1'b0, 8'h02};
        vecs[2] = '{8'hCA, 8'h20, 1'b1, 1'b0, 1'b1, 8'h20};
        vecs[3] = '{8'hC2, 8'h20, 1'b1, 1'b0, 1'b0, 8'h02};
        vecs[4] = '{8'hC2, 8'h20, 1'b0, 1'b0, 1'b1, 8'h20};
        vecs[5] = '{8'hDA, 8'h30, 1'b0, 1'b1, 1'b1, 8'h30};
        vecs[6] = '{8'hD2, 8'h30, 1'b0, 1'b1, 1'b0, 8'h02};
        vecs[7] = '{8'hD2, 8'h30, 1'b0, 1'b0, 1'b1, 8'h30};
        vecs[8] = '{8'hDA, 8'h30, 1'b1, 1'b0, 1'b0, 8'h02};
        vecs[9] = '{8'h3E, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02};

        reset = 1'b1;
        stall = 1'b0;
        apply_stimulus(8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_output("rst_jump",   {7'b0, pc_jump},    8'h00);
        check_output("rst_freeze", {7'b0, pc_freeze},  8'h01);
        check_output("rst_jaddr",  pc_jmpaddr,         8'h00);
        check_output("rst_ir",     ir,                 8'h00);
        check_output("rst_ev",     {7'b0, exec_valid}, 8'h00);
        check_output("rst_halted", {7'b0, halted},     8'h00);
        check_output("rst_err",    {7'b0, stack_err},  8'h00);

        // Branch decode table: operand cycle and target arrival.
        for (int v = 0; v < 10; v++) begin
            apply_stimulus(vecs[v].op, vecs[v].tgt, vecs[v].z, vecs[v].cy);
            do_reset();
            step(1);
            check_output($sformatf("v%0d_ir", v), ir, vecs[v].op);
            check_output($sformatf("v%0d_jump", v), {7'b0, pc_jump}, {7'b0, vecs[v].exp_jump});
            check_output($sformatf("v%0d_jaddr", v), pc_jmpaddr,
                         vecs[v].exp_jump ? vecs[v].tgt : 8'h00);
            step(1);
            check_output($sformatf("v%0d_pc3", v), pc_addr, vecs[v].exp_pc3);
        end

        // Ordinary opcodes, then HLT parks the PC.
        apply_stimulus(8'h3E, 8'h05, 1'b0, 1'b0);
        mem[2] = 8'h76;
        do_reset();
        step(1);
        check_output("ord1_ev", {7'b0, exec_valid}, 8'h01);
        check_output("ord1_ir", ir, 8'h3E);
        step(1);
        check_output("ord2_ev", {7'b0, exec_valid}, 8'h01);
        check_output("ord2_ir", ir, 8'h05);
        check_output("hlt_freeze", {7'b0, pc_freeze}, 8'h01);
        step(1);
        check_output("hlt_halted", {7'b0, halted}, 8'h01);
        check_output("hlt_ev", {7'b0, exec_valid}, 8'h00);
        check_output("hlt_ir", ir, 8'h76);
        step(10);
        check_output("hlt_pc", pc_addr, 8'h02);
        check_output("hlt_halted2", {7'b0, halted}, 8'h01);

        // Stall in FETCH suppresses exec_valid and latches nothing.
        apply_stimulus(8'h11, 8'h22, 1'b0, 1'b0);
        mem[2] = 8'h76;
        do_reset();
        stall = 1'b1;
        #1;
        check_output("fst_freeze", {7'b0, pc_freeze}, 8'h01);
        step(2);
        check_output("fst_pc", pc_addr, 8'h00);
        check_output("fst_ev", {7'b0, exec_valid}, 8'h00);
        check_output("fst_ir", ir, 8'h00);
        stall = 1'b0;
        step(1);
        check_output("fst_ev2", {7'b0, exec_valid}, 8'h01);
        check_output("fst_ir2", ir, 8'h11);

        // CALL 10 / RET back to 02 / HLT.
        apply_stimulus(8'hCD, 8'h10, 1'b0, 1'b0);
        mem[8'h10] = 8'hC9;
        mem[8'h02] = 8'h76;
        do_reset();
        step(1);
        check_output("call_jump", {7'b0, pc_jump}, 8'h01);
        check_output("call_jaddr", pc_jmpaddr, 8'h10);
        step(1);
        check_output("ret_pc", pc_addr, 8'h10);
        check_output("ret_jump", {7'b0, pc_jump}, 8'h01);
        check_output("ret_jaddr", pc_jmpaddr, 8'h02);
        step(1);
        check_output("ret_dest", pc_addr, 8'h02);
        step(1);
        check_output("cr_halted", {7'b0, halted}, 8'h01);
        check_output("cr_err", {7'b0, stack_err}, 8'h00);

        // Five nested CALLs overflow a 4-deep stack; unwind to underflow.
        apply_stimulus(8'hCD, 8'h10, 1'b0, 1'b0);
        mem[8'h10] = 8'hCD; mem[8'h11] = 8'h20;
        mem[8'h20] = 8'hCD; mem[8'h21] = 8'h30;
        mem[8'h30] = 8'hCD; mem[8'h31] = 8'h40;
        mem[8'h40] = 8'hCD; mem[8'h41] = 8'h50;
        mem[8'h42] = 8'hC9; mem[8'h32] = 8'hC9;
        mem[8'h22] = 8'hC9; mem[8'h12] = 8'hC9;
        mem[8'h02] = 8'hC9; mem[8'h03] = 8'h76;
        do_reset();
        step(9);
        check_output("ovf_pc", pc_addr, 8'h41);
        check_output("ovf_jump", {7'b0, pc_jump}, 8'h00);
        check_output("ovf_freeze", {7'b0, pc_freeze}, 8'h00);
        step(1);
        check_output("ovf_fall", pc_addr, 8'h42);
        check_output("ovf_err", {7'b0, stack_err}, 8'h01);
        check_output("pop1_jaddr", pc_jmpaddr, 8'h32);
        step(1);
        check_output("pop2_jaddr", pc_jmpaddr, 8'h22);
        step(1);
        check_output("pop3_jaddr", pc_jmpaddr, 8'h12);
        step(1);
        check_output("pop4_jaddr", pc_jmpaddr, 8'h02);
        step(1);
        check_output("unf_pc", pc_addr, 8'h02);
        check_output("unf_jump", {7'b0, pc_jump}, 8'h00);
        check_output("unf_freeze", {7'b0, pc_freeze}, 8'h00);
        step(1);
        check_output("unf_next", pc_addr, 8'h03);
        check_output("unf_err", {7'b0, stack_err}, 8'h01);
        step(1);
        check_output("unf_halted", {7'b0, halted}, 8'h01);

        // Return address wraps: CALL operand at FF pushes 00.
        apply_stimulus(8'hC3, 8'hFE, 1'b0, 1'b0);
        mem[8'hFE] = 8'hCD; mem[8'hFF] = 8'h50; mem[8'h50] = 8'hC9;
        do_reset();
        step(4);
        check_output("wrap_pc", pc_addr, 8'h50);
        check_output("wrap_jump", {7'b0, pc_jump}, 8'h01);
        check_output("wrap_jaddr", pc_jmpaddr, 8'h00);
        step(1);
        check_output("wrap_dest", pc_addr, 8'h00);

        // Stall held three cycles in the operand cycle of JMP 40.
        apply_stimulus(8'hC3, 8'h40, 1'b0, 1'b0);
        do_reset();
        step(1);
        stall = 1'b1;
        #1;
        check_output("ost_freeze", {7'b0, pc_freeze}, 8'h01);
        check_output("ost_jump", {7'b0, pc_jump}, 8'h00);
        for (int c = 0; c < 3; c++) begin
            step(1);
            check_output($sformatf("ost_pc%0d", c), pc_addr, 8'h01);
            check_output($sformatf("ost_ev%0d", c), {7'b0, exec_valid}, 8'h00);
        end
        stall = 1'b0;
        #1;
        check_output("ost_rel_jump", {7'b0, pc_jump}, 8'h01);
        check_output("ost_rel_jaddr", pc_jmpaddr, 8'h40);
        step(1);
        check_output("ost_dest", pc_addr, 8'h40);

        // Async reset in the operand cycle aborts the branch.
        apply_stimulus(8'hC3, 8'h40, 1'b0, 1'b0);
        do_reset();
        step(1);
        check_output("mid_ir_before", ir, 8'hC3);
        reset = 1'b1;
        #1;
        check_output("mid_ir", ir, 8'h00);
        check_output("mid_freeze", {7'b0, pc_freeze}, 8'h01);
        check_output("mid_jump", {7'b0, pc_jump}, 8'h00);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(2);
        check_output("mid_restart_pc", pc_addr, 8'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
